// File: rtl/fp_sub.sv
// Registered floating-point subtractor (op_a - op_b) for binary32 / binary16, selected per cycle.
// Subnormals flush to zero; RNE or RTZ rounding; one-cycle latency.
`timescale 1ns/1ps
module fp_sub (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        round_mode,
    input  logic        mode_fp,
    output logic [31:0] result
);

    logic [31:0] result_q, result_d;

    logic        sa, sb;
    logic [7:0]  ea, eb, emax;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    logic               s_l, s_s;
    logic [7:0]         e_l, e_s, d;
    logic [22:0]        f_l, f_s;
    logic [4:0]         sh_amt, lz;
    logic [53:0]        sh;
    logic [26:0]        big_x, small_x, norm;
    logic [27:0]        sum;
    logic signed [9:0]  exp_n, exp_r;
    logic               g, r, s, lsb, inc, carry;
    logic [24:0]        rs;
    logic [22:0]        frac_r;

    function automatic logic [31:0] pack(input logic fp32, input logic sgn,
                                         input logic [7:0] e, input logic [22:0] f);
        if (fp32)
            pack = {sgn, e, f};
        else
            pack = {16'd0, sgn, e[4:0], f[22:13]};
    endfunction

    // Half operands are widened so their fraction sits in the top 10 bits of
    // the binary32 field; the lower 13 bits then act as extra precision.
    always_comb begin
        if (mode_fp) begin
            sa   = op_a[31];
            ea   = op_a[30:23];
            fa   = op_a[22:0];
            sb   = ~op_b[31];
            eb   = op_b[30:23];
            fb   = op_b[22:0];
            emax = 8'hFF;
        end else begin
            sa   = op_a[15];
            ea   = {3'd0, op_a[14:10]};
            fa   = {op_a[9:0], 13'd0};
            sb   = ~op_b[15];
            eb   = {3'd0, op_b[14:10]};
            fb   = {op_b[9:0], 13'd0};
            emax = 8'h1F;
        end
    end

    assign a_nan  = (ea == emax) && (fa != 23'd0);
    assign b_nan  = (eb == emax) && (fb != 23'd0);
    assign a_inf  = (ea == emax) && (fa == 23'd0);
    assign b_inf  = (eb == emax) && (fb == 23'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    always_comb begin
        if ({ea, fa} >= {eb, fb}) begin
            s_l = sa; e_l = ea; f_l = fa;
            s_s = sb; e_s = eb; f_s = fb;
        end else begin
            s_l = sb; e_l = eb; f_l = fb;
            s_s = sa; e_s = ea; f_s = fa;
        end

        d       = e_l - e_s;
        sh_amt  = (d > 8'd27) ? 5'd27 : d[4:0];
        sh      = {1'b1, f_s, 3'b000, 27'd0} >> sh_amt;
        small_x = {sh[53:28], sh[27] | (|sh[26:0])};
        big_x   = {1'b1, f_l, 3'b000};

        if (s_l != s_s)
            sum = {1'b0, big_x} - {1'b0, small_x};
        else
            sum = {1'b0, big_x} + {1'b0, small_x};

        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, e_l}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, e_l}) - $signed({5'd0, lz});
        end

        // Round position depends on format: LSB at bit 3 (binary32) or 16 (binary16).
        if (mode_fp) begin
            lsb = norm[3];
            g   = norm[2];
            r   = norm[1];
            s   = norm[0];
        end else begin
            lsb = norm[16];
            g   = norm[15];
            r   = norm[14];
            s   = |norm[13:0];
        end
        inc = ~round_mode & g & (r | s | lsb);

        if (mode_fp) begin
            rs     = {1'b0, norm[26:3]} + {24'd0, inc};
            carry  = rs[24];
            frac_r = rs[22:0];
        end else begin
            rs     = {14'd0, norm[26:16]} + {24'd0, inc};
            carry  = rs[11];
            frac_r = {rs[9:0], 13'd0};
        end
        exp_r = exp_n + $signed({9'd0, carry});
    end

    always_comb begin
        result_d = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            result_d = pack(mode_fp, 1'b0, emax, 23'h400000);
        else if (a_inf)
            result_d = pack(mode_fp, sa, emax, 23'd0);
        else if (b_inf)
            result_d = pack(mode_fp, sb, emax, 23'd0);
        else if (a_zero && b_zero)
            result_d = pack(mode_fp, sa & sb, 8'd0, 23'd0);
        else if (a_zero)
            result_d = pack(mode_fp, sb, eb, fb);
        else if (b_zero)
            result_d = pack(mode_fp, sa, ea, fa);
        else if (sum == 28'd0)
            result_d = 32'd0;
        else if (exp_r < 10'sd1)
            result_d = pack(mode_fp, s_l, 8'd0, 23'd0);
        else if (exp_r >= $signed({2'b00, emax}))
            result_d = round_mode ? pack(mode_fp, s_l, emax - 8'd1, 23'h7FFFFF)
                                  : pack(mode_fp, s_l, emax, 23'd0);
        else
            result_d = pack(mode_fp, s_l, exp_r[7:0], frac_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result_q <= 32'd0;
        else
            result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: tb/tb_fp_sub.sv
// Scoreboard bench for fp_sub: expected differences are queued at drive time
// and compared one cycle later, plus async-reset and hold-between-edges checks.
`timescale 1ns/1ps
module tb_fp_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic        round_mode, mode_fp;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic        fp;
        logic [31:0] y;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] last_exp;

    fp_sub dut (
        .clk        (clk),
        .rst        (rst),
        .op_a       (op_a),
        .op_b       (op_b),
        .round_mode (round_mode),
        .mode_fp    (mode_fp),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive at the falling edge; until the next rising edge the output must
    // still hold the previous capture.
    task automatic drive_vec(input string tag, input vec_t v);
        @(negedge clk);
        op_a       = v.a;
        op_b       = v.b;
        round_mode = v.rm;
        mode_fp    = v.fp;
        exp_q.push_back(v.y);
        tag_q.push_back(tag);
        #1;
        check_val({tag, "/hold"}, result, last_exp);
        last_exp = v.y;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++)
            @(posedge clk);
        #2;
        check_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check_val(tag_q.pop_front(), result, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // a, b, round_mode, mode_fp, expected
        vecs.push_back('{32'h46800000, 32'h44000000, 1'b0, 1'b1, 32'h46780000});
        vecs.push_back('{32'hB8F80000, 32'h3F800000, 1'b0, 1'b1, 32'hBF8003E0});
        vecs.push_back('{32'h40300000, 32'hBFC00000, 1'b0, 1'b1, 32'h40880000});
        vecs.push_back('{32'hC0700000, 32'hC0200000, 1'b0, 1'b1, 32'hBFA00000});
        vecs.push_back('{32'h00004800, 32'h00004000, 1'b0, 1'b0, 32'h00004600});
        vecs.push_back('{32'h0000BC00, 32'h00003C00, 1'b0, 1'b0, 32'h0000C000});
        vecs.push_back('{32'h00004140, 32'h0000BE00, 1'b0, 1'b0, 32'h00004420});
        vecs.push_back('{32'h0000C070, 32'h0000C020, 1'b0, 1'b0, 32'h0000B100});
        vecs.push_back('{32'h00000000, 32'h00003C00, 1'b0, 1'b0, 32'h0000BC00});
        vecs.push_back('{32'hFFFF4800, 32'h12344000, 1'b0, 1'b0, 32'h00004600});
        // exact 1 - 2^-24 - 2^-47: nearest is 3F7FFFFF, truncation one ulp lower
        vecs.push_back('{32'h3F800000, 32'h33800001, 1'b0, 1'b1, 32'h3F7FFFFF});
        vecs.push_back('{32'h3F800000, 32'h33800001, 1'b1, 1'b1, 32'h3F7FFFFE});
        // 2^24+3 is a tie between odd ...01 and even ...02
        vecs.push_back('{32'h4B800001, 32'hBF800000, 1'b0, 1'b1, 32'h4B800002});
        vecs.push_back('{32'h4B800001, 32'hBF800000, 1'b1, 1'b1, 32'h4B800001});
        // half: 2050 + 1 = 2051, tie between 2050 and 2052
        vecs.push_back('{32'h00006801, 32'h0000BC00, 1'b0, 1'b0, 32'h00006802});
        vecs.push_back('{32'h00006801, 32'h0000BC00, 1'b1, 1'b0, 32'h00006801});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 32'h7FC00000});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h00000000});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 1'b1, 32'h00000000});
        vecs.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 1'b0, 1'b1, 32'h7F800000});
        vecs.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1, 1'b1, 32'h7F7FFFFF});
        vecs.push_back('{32'h00007C00, 32'h0000FC00, 1'b0, 1'b0, 32'h00007C00});
        vecs.push_back('{32'h80000000, 32'h00000000, 1'b0, 1'b1, 32'h80000000});
        vecs.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 32'hFF800000});
        vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b0, 1'b1, 32'hFF800000});
        vecs.push_back('{32'h00000001, 32'h3F800000, 1'b0, 1'b1, 32'hBF800000});
        vecs.push_back('{32'h80800001, 32'h80800000, 1'b0, 1'b1, 32'h80000000});
        vecs.push_back('{32'h00007C01, 32'h00003C00, 1'b0, 1'b0, 32'h00007E00});
        vecs.push_back('{32'h00007BFF, 32'h0000FBFF, 1'b0, 1'b0, 32'h00007C00});
        vecs.push_back('{32'h00007BFF, 32'h0000FBFF, 1'b1, 1'b0, 32'h00007BFF});
        vecs.push_back('{32'h00003C00, 32'h00003C00, 1'b0, 1'b0, 32'h00000000});

        rst        = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        round_mode = 1'b0;
        mode_fp    = 1'b1;
        last_exp   = 32'd0;

        #1 rst = 1'b1;
        #1 check_val("rst_async", result, 32'd0);
        repeat (2) @(posedge clk);
        #1 check_val("rst_hold", result, 32'd0);

        // Inputs are already valid when reset releases: first edge must capture them.
        drive_vec("v0", vecs[0]);
        rst = 1'b0;
        for (int i = 1; i < vecs.size(); i++)
            drive_vec($sformatf("v%0d", i), vecs[i]);
        drain("drain1");

        drive_vec("pre_rst", vecs[2]);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_val("rst_mid", result, 32'd0);
        last_exp = 32'd0;
        @(posedge clk);
        #1 check_val("rst_mid_hold", result, 32'd0);

        drive_vec("post_rst", vecs[6]);
        rst = 1'b0;
        drive_vec("post_rst2", vecs[1]);
        drain("drain2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
